// File: rtl/imm_pkg.sv
// imm_pkg: shared mode and state encodings
// for the immediate-extension stage.
package imm_pkg;

  localparam logic [1:0] IMM_ZERO   = 2'b00;
  localparam logic [1:0] IMM_SIGN   = 2'b01;
  localparam logic [1:0] IMM_UPPER  = 2'b10;
  localparam logic [1:0] IMM_BRANCH = 2'b11;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/imm_ext_func.sv
// imm_ext_func: combinational extender.
// in: imm[IN_W], mode[2]; out: ext[OUT_W].
module imm_ext_func
  import imm_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext
);

  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = {{PAD{1'b0}}, imm};
  assign sext = {{PAD{imm[IN_W-1]}}, imm};

  always_comb begin
    ext = zext;
    unique case (mode)
      IMM_ZERO:   ext = zext;
      IMM_SIGN:   ext = sext;
      IMM_UPPER:  ext = {imm, {PAD{1'b0}}};
      IMM_BRANCH: ext = sext << BR_SHIFT;
      default:    ext = zext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered extender, 2-entry skid.
// in_*/out_* valid-ready, flush, occ[2].
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occ
);

  logic [1:0]       state;
  logic [OUT_W-1:0] main_imm;
  logic [TAG_W-1:0] main_tag;
  logic [OUT_W-1:0] skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic [OUT_W-1:0] new_imm;
  logic             main_valid;
  logic             skid_valid;
  logic             accept;
  logic             consume;

  imm_ext_func #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .BR_SHIFT(BR_SHIFT)
  ) u_func (
    .imm (in_imm),
    .mode(in_mode),
    .ext (new_imm)
  );

  assign main_valid = (state != ST_EMPTY);
  assign skid_valid = (state == ST_FULL);
  assign in_ready   = !skid_valid && !rst;
  assign accept     = in_valid && in_ready;
  assign consume    = main_valid && out_ready;

  assign out_valid = main_valid;
  assign out_imm   = main_imm;
  assign out_tag   = main_tag;
  assign occ       = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      main_imm <= '0;
      main_tag <= '0;
      skid_imm <= '0;
      skid_tag <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_imm <= new_imm;
            main_tag <= in_tag;
            state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_imm <= new_imm;
            main_tag <= in_tag;
          end else if (accept) begin
            skid_imm <= new_imm;
            skid_tag <= in_tag;
            state    <= ST_FULL;
          end else if (consume) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_imm <= skid_imm;
            main_tag <= skid_tag;
            state    <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed vector bench
// for imm_ext_pipe (default parameters).
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;
  logic [1:0]  occ;

  int vectors;
  int miscompares;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [9];

  imm_ext_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm  (out_imm),
    .out_tag  (out_tag),
    .occ      (occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] imm,
                      input logic [1:0] mode,
                      input logic [4:0] tag);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    tbl[0] = '{2'b00, 16'h8004, 5'd1, 32'h00008004};
    tbl[1] = '{2'b01, 16'h8004, 5'd2, 32'hFFFF8004};
    tbl[2] = '{2'b10, 16'h8004, 5'd3, 32'h80040000};
    tbl[3] = '{2'b11, 16'h8004, 5'd4, 32'hFFFE0010};
    tbl[4] = '{2'b01, 16'h7FFF, 5'd5, 32'h00007FFF};
    tbl[5] = '{2'b11, 16'h7FFF, 5'd6, 32'h0001FFFC};
    tbl[6] = '{2'b10, 16'hFFFF, 5'd7, 32'hFFFF0000};
    tbl[7] = '{2'b00, 16'hFFFF, 5'd8, 32'h0000FFFF};
    tbl[8] = '{2'b11, 16'hFFFF, 5'd9, 32'hFFFFFFFC};

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_imm    = 16'h5555;
    in_mode   = 2'b01;
    in_tag    = 5'd3;
    out_ready = 1'b0;

    #1;
    chk("rst_in_ready0", 32'(in_ready), 32'd0);
    step();
    chk("rst_in_ready1", 32'(in_ready), 32'd0);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].imm, tbl[i].mode, tbl[i].tag);
      chk($sformatf("mode_v%0d_valid", i),
          32'(out_valid), 32'd1);
      chk($sformatf("mode_v%0d_imm", i),
          out_imm, tbl[i].exp);
      chk($sformatf("mode_v%0d_tag", i),
          32'(out_tag), 32'(tbl[i].tag));
      chk($sformatf("mode_v%0d_occ", i),
          32'(occ), 32'd1);
    end
    step();
    chk("mode_drain_occ", 32'(occ), 32'd0);

    out_ready = 1'b0;
    send(16'h0001, 2'b00, 5'd7);
    chk("bp_occ1", 32'(occ), 32'd1);
    send(16'h0002, 2'b00, 5'd8);
    chk("bp_occ2", 32'(occ), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_imm", out_imm, 32'h1);
    in_valid = 1'b1;
    in_imm   = 16'h0003;
    step();
    in_valid = 1'b0;
    chk("bp_hold2_imm", out_imm, 32'h1);
    chk("bp_hold2_tag", 32'(out_tag), 32'd7);
    chk("bp_hold2_occ", 32'(occ), 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_first_imm", out_imm, 32'h1);
    chk("bp_first_tag", 32'(out_tag), 32'd7);
    step();
    chk("bp_second_imm", out_imm, 32'h2);
    chk("bp_second_tag", 32'(out_tag), 32'd8);
    chk("bp_second_occ", 32'(occ), 32'd1);
    step();
    chk("bp_empty_occ", 32'(occ), 32'd0);
    chk("bp_empty_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      send(16'(i), 2'b01, 5'(i));
      chk($sformatf("tp_%0d_imm", i),
          out_imm, 32'(i));
      chk($sformatf("tp_%0d_tag", i),
          32'(out_tag), 32'(i));
      chk($sformatf("tp_%0d_occ", i),
          32'(occ), 32'd1);
      chk($sformatf("tp_%0d_rdy", i),
          32'(in_ready), 32'd1);
    end
    step();
    chk("tp_drain_occ", 32'(occ), 32'd0);

    out_ready = 1'b0;
    send(16'h0011, 2'b00, 5'd1);
    send(16'h0022, 2'b00, 5'd2);
    chk("fl_full_occ", 32'(occ), 32'd2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_imm   = 16'h1234;
    in_mode  = 2'b00;
    in_tag   = 5'd9;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ", 32'(occ), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("fl_gone_%0d", i),
          32'(out_valid), 32'd0);
    end

    out_ready = 1'b0;
    send(16'h00AA, 2'b00, 5'd4);
    send(16'h00BB, 2'b00, 5'd5);
    chk("rm_full_occ", 32'(occ), 32'd2);
    rst   = 1'b1;
    flush = 1'b1;
    #1;
    chk("rm_in_ready", 32'(in_ready), 32'd0);
    step();
    rst   = 1'b0;
    flush = 1'b0;
    #1;
    chk("rm_occ", 32'(occ), 32'd0);
    chk("rm_out_valid", 32'(out_valid), 32'd0);
    chk("rm_out_imm", out_imm, 32'd0);
    chk("rm_out_tag", 32'(out_tag), 32'd0);
    chk("rm_in_ready1", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(16'h8004, 2'b11, 5'd3);
    chk("rm_new_valid", 32'(out_valid), 32'd1);
    chk("rm_new_imm", out_imm, 32'hFFFE0010);
    chk("rm_new_tag", 32'(out_tag), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, registered immediate-extension stage for the pipelined datapath. Each accepted request carries an IN_W-bit immediate, a 2-bit mode and a TAG_W-bit tag, such as a destination register index. The stage produces the OUT_W-bit extended value through a 2-entry skid buffer with valid/ready handshakes on both sides. It sits between the decode stage and the execute-stage operand mux, and supports stall (backpressure) and flush.

Parameters:
IN_W, 16, immediate input width
OUT_W, 32, extended output width; must satisfy OUT_W > IN_W
BR_SHIFT, 2, left shift applied in branch mode; must satisfy IN_W+BR_SHIFT <= OUT_W
TAG_W, 5, width of the tag that passes through unchanged

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous; drops all buffered entries
in_valid  in  1  request valid
in_ready  out  1  stage can accept a request this cycle
in_imm  in  IN_W  raw immediate
in_mode  in  2  00 zero, 01 sign, 10 upper, 11 branch
in_tag  in  TAG_W  tag, passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_imm  out  OUT_W  extended immediate
out_tag  out  TAG_W  tag paired with out_imm
occ  out  2  number of buffered entries (0..2)

Behaviour:
- Extension function, computed combinationally on input and stored at acceptance:
  - 00 zero: zero-extend in_imm.
  - 01 sign: replicate in_imm[IN_W-1] into the upper bits.
  - 10 upper: in_imm << (OUT_W-IN_W), low bits 0.
  - 11 branch: sign-extend, then << BR_SHIFT; no bits are lost given the parameter constraint.
- Transfer rules:
  - Accept when in_valid & in_ready at a rising edge.
  - Consume when out_valid & out_ready at a rising edge.
- Storage: main register (drives out_*) and skid register.
- State encodes occupancy: EMPTY (occ=0), ONE (main valid, occ=1), FULL (main+skid valid, occ=2).
- in_ready = !skid_valid & !rst. It depends on state registers only; there is no combinational path from out_ready.
- out_valid = main_valid. out_imm and out_tag are held stable while out_valid=1 and out_ready=0.
- Latency: a request accepted at edge N is on out_* after edge N, when main is empty or is being consumed at N.
- Ordering is strictly FIFO.
- Transitions:
  - EMPTY: accept -> ONE (main <= new).
  - ONE:
    - accept & consume -> ONE (main <= new).
    - accept only -> FULL (skid <= new).
    - consume only -> EMPTY.
    - neither -> hold.
  - FULL (in_ready=0):
    - consume -> ONE (main <= skid).
    - otherwise hold.
- Reset (rst=1 at edge): main_valid=0, skid_valid=0, occ=0, out_valid=0, out_imm=0, out_tag=0.
  - in_ready reads 0 while rst=1.
  - Any in_valid during reset is ignored.
  - Reset mid-transfer discards both entries.
- Flush (rst=0, flush=1 at edge):
  - Both entries are invalidated; occ becomes 0.
  - A same-cycle accept is dropped.
  - A same-cycle consume still counts as taken by the consumer.
  - out_imm and out_tag data need not be cleared.
  - rst has priority over flush.
- Simultaneous flush and FULL: the result is EMPTY next cycle, and in_ready=1.
- Unknown/X inputs while in_valid=0 have no effect on state.

Decomposition:
- Shared package imm_pkg holds:
  - mode localparams IMM_ZERO=2'b00, IMM_SIGN=2'b01, IMM_UPPER=2'b10, IMM_BRANCH=2'b11;
  - the state encoding ST_EMPTY/ST_ONE/ST_FULL.
- One combinational sub-module, imm_ext_func (params IN_W, OUT_W, BR_SHIFT; inputs imm and mode; output ext).
  - It replaces the old fixed 16->32 extender.
  - It is reusable by the decode-stage forwarding logic.
- The skid-buffer control stays in imm_ext_pipe.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1 -> after release, out_valid=0, occ=0, out_imm=0; in_ready=0 during rst and 1 after.
2. Modes, with out_ready=1 and in_imm=16'h8004:
   - mode00 -> 32'h00008004;
   - mode01 -> 32'hFFFF8004;
   - mode10 -> 32'h80040000;
   - mode11 -> 32'hFFFE0010.
   Each result appears 1 cycle after acceptance; tags 1,2,3,4 come out in order.
3. Backpressure: out_ready=0, send imm 16'h0001 (tag 7) then 16'h0002 (tag 8) -> occ=2, in_ready=0, out_imm holds 32'h1.
   Then raise out_ready -> 32'h1/tag7, then 32'h2/tag8 on consecutive cycles; occ goes 2->1->0.
4. Full throughput: in_valid=1 and out_ready=1 for 8 cycles with imm 0..7 in mode01 -> 8 results, one per cycle, occ stays 1, in_ready stays 1.
5. Flush: in FULL, assert flush together with in_valid (imm 16'h1234) -> next cycle occ=0, out_valid=0, in_ready=1; 16'h1234 never appears on the output.
6. Reset mid-operation: at occ=2, rst for 1 cycle together with flush=1 -> all outputs reach reset values; the next accepted request produces a correct result 1 cycle later.
